// File: rtl/router_switch_allocator.sv
// Switch allocator for one mesh router: XY-routes each input's destination and
// grants every output port to one requester at a time, rotating priority per output.
module router_switch_allocator #(
    parameter int ROUTER_X = 0,
    parameter int ROUTER_Y = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  req_port,
    input  logic [19:0] dest,
    output logic [4:0]  grant_port,
    output logic [4:0]  out_valid,
    output logic [14:0] out_sel
);
    localparam logic [2:0] P_LOCAL = 3'd0;
    localparam logic [2:0] P_NORTH = 3'd1;
    localparam logic [2:0] P_EAST  = 3'd2;
    localparam logic [2:0] P_SOUTH = 3'd3;
    localparam logic [2:0] P_WEST  = 3'd4;
    localparam logic [1:0] RX = 2'(ROUTER_X);
    localparam logic [1:0] RY = 2'(ROUTER_Y);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t     state_q [5];
    state_t     state_d [5];
    logic [2:0] sel_q   [5];
    logic [2:0] sel_d   [5];
    logic [2:0] last_q  [5];
    logic [2:0] last_d  [5];
    logic [4:0] grant_q;
    logic [4:0] grant_d;
    logic [2:0] route_v [5];
    logic [4:0] cand    [5];
    logic [3:0] pick_v  [5];

    function automatic logic [2:0] route(input logic [3:0] d);
        if (d[1:0] > RX)      return P_EAST;
        else if (d[1:0] < RX) return P_WEST;
        else if (d[3:2] > RY) return P_SOUTH;
        else if (d[3:2] < RY) return P_NORTH;
        else                  return P_LOCAL;
    endfunction

    function automatic logic [2:0] wrap_add(input logic [2:0] ptr, input int k);
        int s;
        s = int'(ptr) + k;
        if (s >= 5) s = s - 5;
        return 3'(s);
    endfunction

    // Returns {found, index}: first candidate after the last winner, modulo 5.
    function automatic logic [3:0] pick(input logic [4:0] c, input logic [2:0] last);
        logic [3:0] res;
        logic [2:0] idx;
        res = 4'd0;
        for (int k = 5; k >= 1; k--) begin
            idx = wrap_add(last, k);
            if (c[idx]) res = {1'b1, idx};
        end
        return res;
    endfunction

    always_comb begin
        for (int i = 0; i < 5; i++) begin
            route_v[i] = route(dest[4*i +: 4]);
        end
        for (int o = 0; o < 5; o++) begin
            for (int i = 0; i < 5; i++) begin
                cand[o][i] = req_port[i] && (route_v[i] == 3'(o)) && !grant_q[i];
            end
            pick_v[o] = pick(cand[o], last_q[o]);
        end
    end

    always_comb begin
        grant_d = grant_q;
        for (int o = 0; o < 5; o++) begin
            state_d[o] = state_q[o];
            sel_d[o]   = sel_q[o];
            last_d[o]  = last_q[o];
            if (state_q[o] == BUSY) begin
                if (!req_port[sel_q[o]]) begin
                    grant_d[sel_q[o]] = 1'b0;
                    state_d[o]        = IDLE;
                end
            end else if (pick_v[o][3]) begin
                grant_d[pick_v[o][2:0]] = 1'b1;
                sel_d[o]                = pick_v[o][2:0];
                last_d[o]               = pick_v[o][2:0];
                state_d[o]              = BUSY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q <= 5'd0;
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= IDLE;
                sel_q[o]   <= 3'd0;
                last_q[o]  <= 3'd4;
            end
        end else begin
            grant_q <= grant_d;
            for (int o = 0; o < 5; o++) begin
                state_q[o] <= state_d[o];
                sel_q[o]   <= sel_d[o];
                last_q[o]  <= last_d[o];
            end
        end
    end

    always_comb begin
        grant_port = grant_q;
        for (int o = 0; o < 5; o++) begin
            out_valid[o]       = (state_q[o] == BUSY);
            out_sel[3*o +: 3]  = sel_q[o];
        end
    end
endmodule

// File: tb/tb_router_switch_allocator.sv
// Bench for router_switch_allocator at router (1,1): directed scenarios followed by
// randomized traffic, all checked against an integer-level allocation model.
module tb_router_switch_allocator;
    localparam int RX = 1;
    localparam int RY = 1;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  req_port;
    logic [19:0] dest;
    logic [4:0]  grant_port;
    logic [4:0]  out_valid;
    logic [14:0] out_sel;

    int checks   = 0;
    int failures = 0;

    // Model: which input owns each output (-1 = free), rotation pointer, last select.
    int       m_owner [5];
    int       m_last  [5];
    int       m_sel   [5];
    bit [4:0] m_grant;

    router_switch_allocator #(.ROUTER_X(RX), .ROUTER_Y(RY)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_port   (req_port),
        .dest       (dest),
        .grant_port (grant_port),
        .out_valid  (out_valid),
        .out_sel    (out_sel)
    );

    always #5 clk = ~clk;

    function automatic int route_m(input int d);
        int x, y;
        x = d % 4;
        y = (d / 4) % 4;
        if (x > RX) return 2;
        if (x < RX) return 4;
        if (y > RY) return 3;
        if (y < RY) return 1;
        return 0;
    endfunction

    task automatic model_edge();
        bit [4:0] ng;
        int       i;
        bit       found;
        if (!rst) begin
            for (int o = 0; o < 5; o++) begin
                m_owner[o] = -1;
                m_last[o]  = 4;
                m_sel[o]   = 0;
            end
            m_grant = '0;
        end else begin
            ng = m_grant;
            for (int o = 0; o < 5; o++) begin
                if (m_owner[o] >= 0) begin
                    if (!req_port[m_owner[o]]) begin
                        ng[m_owner[o]] = 1'b0;
                        m_owner[o]     = -1;
                    end
                end else begin
                    found = 1'b0;
                    for (int k = 1; k <= 5; k++) begin
                        i = (m_last[o] + k) % 5;
                        if (!found && req_port[i] && !m_grant[i] &&
                            route_m(int'(dest[4*i +: 4])) == o) begin
                            found      = 1'b1;
                            ng[i]      = 1'b1;
                            m_owner[o] = i;
                            m_sel[o]   = i;
                            m_last[o]  = i;
                        end
                    end
                end
            end
            m_grant = ng;
        end
    endtask

    task automatic expect_eq(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        logic [4:0]  ev;
        logic [14:0] es;
        int          s;
        for (int o = 0; o < 5; o++) begin
            ev[o] = (m_owner[o] >= 0);
            s = m_sel[o];
            es[3*o +: 3] = 3'(s);
        end
        expect_eq("model_grant", {10'd0, grant_port}, {10'd0, m_grant});
        expect_eq("model_valid", {10'd0, out_valid}, {10'd0, ev});
        expect_eq("model_sel", out_sel, es);
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_model();
    endtask

    initial begin
        logic [4:0] flip;
        rst      = 1'b0;
        req_port = 5'($urandom);
        dest     = 20'($urandom);
        for (int o = 0; o < 5; o++) begin
            m_owner[o] = -1;
            m_last[o]  = 4;
            m_sel[o]   = 0;
        end
        m_grant = '0;

        // Reset with random requests held, then release reset.
        cycle();
        cycle();
        expect_eq("reset_grant", {10'd0, grant_port}, 15'd0);
        expect_eq("reset_valid", {10'd0, out_valid}, 15'd0);
        expect_eq("reset_sel", out_sel, 15'd0);
        rst = 1'b1;
        cycle();
        req_port = 5'b00000;
        cycle();
        cycle();
        expect_eq("idle_after_drop", {10'd0, grant_port}, 15'd0);

        // East route from input 0.
        req_port = 5'b00001;
        dest     = 20'h00007;
        cycle();
        expect_eq("east_grant", {10'd0, grant_port}, 15'b00001);
        expect_eq("east_valid", {10'd0, out_valid}, 15'b00100);
        expect_eq("east_sel", {12'd0, out_sel[8:6]}, 15'd0);
        req_port = 5'b00000;
        cycle();
        expect_eq("east_release", {10'd0, grant_port}, 15'd0);

        // South route from input 1.
        req_port = 5'b00010;
        dest     = 20'h000D0;
        cycle();
        expect_eq("south_grant", {10'd0, grant_port}, 15'b00010);
        expect_eq("south_valid", {10'd0, out_valid}, 15'b01000);
        expect_eq("south_sel", {12'd0, out_sel[11:9]}, 15'd1);
        req_port = 5'b00000;
        cycle();

        // Contention for Local between inputs 1 and 3, straight after reset.
        rst = 1'b0;
        cycle();
        rst      = 1'b1;
        req_port = 5'b01010;
        dest     = 20'h05050;
        cycle();
        expect_eq("cont_first", {10'd0, grant_port}, 15'b00010);
        req_port = 5'b01000;
        cycle();
        expect_eq("cont_release", {10'd0, grant_port}, 15'd0);
        cycle();
        expect_eq("cont_second", {10'd0, grant_port}, 15'b01000);
        expect_eq("cont_second_sel", {12'd0, out_sel[2:0]}, 15'd3);
        req_port = 5'b00000;
        cycle();
        req_port = 5'b01010;
        cycle();
        expect_eq("cont_rotate", {10'd0, grant_port}, 15'b00010);
        req_port = 5'b00000;
        cycle();

        // Parallel grants: input 0 East, input 4 North.
        req_port = 5'b10001;
        dest     = 20'h10007;
        cycle();
        expect_eq("par_grant", {10'd0, grant_port}, 15'b10001);
        expect_eq("par_valid", {10'd0, out_valid}, 15'b00110);
        req_port = 5'b00000;
        cycle();

        // Reset in the middle of a packet on input 2 (West).
        req_port = 5'b00100;
        dest     = 20'h00400;
        cycle();
        expect_eq("mid_grant", {10'd0, grant_port}, 15'b00100);
        rst = 1'b0;
        cycle();
        expect_eq("mid_reset", {10'd0, grant_port}, 15'd0);
        rst = 1'b1;
        cycle();
        expect_eq("mid_regrant", {10'd0, grant_port}, 15'b00100);
        req_port = 5'b00000;
        cycle();

        // Randomized traffic: requests mostly held, dest churns, occasional reset.
        for (int n = 0; n < 400; n++) begin
            for (int b = 0; b < 5; b++) flip[b] = ($urandom_range(0, 3) == 0);
            req_port = req_port ^ flip;
            dest     = 20'($urandom);
            rst      = ($urandom_range(0, 49) != 0);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/router_switch_allocator.md
# router_switch_allocator

Per-router switch allocator for the 4x4 mesh NoC. It collects the `req_port`/`dest` requests from the router's five `buffer_unit` instances and computes each requester's output port with XY routing. It arbitrates each output port round-robin among its requesters, returns `grant_port` to the winning buffer unit, and drives the crossbar select for the packet's duration.

## Interface
Parameters:
- `ROUTER_X`, default 0: router column, 0..3.
- `ROUTER_Y`, default 0: router row, 0..3.

Ports (index order everywhere: 0=Local, 1=North, 2=East, 3=South, 4=West):
- `clk`  input  1  clock; all state updates on rising edge.
- `rst`  input  1  one clock; reset is synchronous and active-low.
- `req_port`  input  5  `req_port[i]` from input buffer unit i; held high for the whole packet.
- `dest`  input  20  `dest[4i+3:4i]` is buffer unit i's registered destination; `{y[1:0], x[1:0]}`.
- `grant_port`  output  5  `grant_port[i]` goes to buffer unit i.
- `out_valid`  output  5  output port o is currently allocated.
- `out_sel`  output  15  `out_sel[3o+2:3o]` is the input index driving output o's crossbar mux.

## Operation
- Routing is combinational per input; dest x = `dest[1:0]`, y = `dest[3:2]`.
  - x > ROUTER_X → East; x < ROUTER_X → West.
  - Otherwise y > ROUTER_Y → South; y < ROUTER_Y → North.
  - Otherwise → Local.
  - Compares are unsigned 2-bit.
- Each output port o has its own 2-state FSM and a 3-bit round-robin pointer `last[o]` (range 0..4).
- **IDLE**
  - Candidate set = inputs i with `req_port[i]`=1, route(i)=o and `grant_port[i]`=0.
  - Winner = first candidate scanning `last[o]+1`, `+2`, … modulo 5.
  - On a winner: `grant_port[w]`←1, `out_sel[o]`←w, `out_valid[o]`←1, `last[o]`←w, go to BUSY.
  - No candidate: stay in IDLE.
- **BUSY**
  - While `req_port[out_sel[o]]`=1: hold all state.
  - When it is sampled 0: `grant_port[w]`←0, `out_valid[o]`←0, go to IDLE.
  - `out_sel[o]` keeps its last value.
- `dest` is used only at the arbitration edge. Changes to `dest` while BUSY are ignored; the route does not change mid-packet.
- An input requests only one output, so different outputs arbitrate independently. Up to 5 grants can be issued on the same edge.
- U-turn (route(i)=i) is not filtered; it is granted like any other request.

## Timing
- Reset (`rst`=0 at an edge): `grant_port`=0, `out_valid`=0, `out_sel`=0, every `last[o]`=4 (input 0 has first priority), all FSMs IDLE.
  - Reset overrides any in-flight allocation on that edge.
  - A request still held after reset is re-arbitrated on the first edge with `rst`=1.
- Grant latency: `req_port[i]` sampled high at edge k with its output IDLE and i winning → `grant_port[i]`=1 after edge k.
- Release latency: `req_port[i]` sampled low at edge m → `grant_port[i]`=0 after edge m.
  - Earliest next grant on that output is edge m+1, so there is at least one idle cycle between packets on an output.
- A losing requester keeps `req_port` high and receives no grant. It is reconsidered at every IDLE edge.
- A request that rises and falls between edges is never seen; no grant is issued.
- `grant_port` is never high for two outputs or two winners of the same output; it is one-hot per output.

## Test plan
- Reset: hold `rst`=0 for 2 cycles with random `req_port` → all outputs 0; first edge after `rst`=1 arbitrates the held requests.
- East route: ROUTER_X=1, ROUTER_Y=1; `req_port`=5'b00001, `dest[3:0]`=4'b0111.
  - → `grant_port[0]`=1 one edge later; `out_valid[2]`=1; `out_sel[8:6]`=0.
  - Drop req → grant 0 one edge later.
- South route: same router; input 1 with `dest[7:4]`=4'b1101 → `out_valid[3]`=1, `out_sel[11:9]`=1, `grant_port[1]`=1.
- Contention: inputs 1 and 3 both with dest 4'b0101 (Local) on the same edge after reset.
  - → input 1 granted first.
  - After release and one idle cycle → input 3 granted.
  - Repeat both requests → input 1 wins (pointer rotated to 3).
- Parallel: input 0 → East and input 4 → North on the same edge → `grant_port`=5'b10001 after one edge; `out_valid`=5'b00110.
- Reset mid-packet: with `grant_port[2]`=1, pulse `rst`=0 for one edge while `req_port[2]` stays high.
  - → grant 0 after that edge.
  - → regranted one edge after `rst` returns to 1.
